// File: rtl/timer_share_arbiter.sv
// ---------------------------------------------------------------------------
// timer_share_arbiter
//
// Shares one CntWidth-bit down-counting period timer among four requesting
// application FSMs. A round-robin arbiter picks an owner among the pending
// requests. The block then loads that owner's period into the counter and
// runs the counter down to zero. At expiry it returns a one-cycle done pulse
// to the owner. The timer hardware therefore exists only once, however many
// requesters share it.
//
// Ports:
//   Reset_n_i  in   1            asynchronous, active-low reset
//   Clk_i      in   1            clock, rising edge
//   Enable_i   in   1            global enable; low aborts a run and blocks
//                                new grants
//   Req_i      in   4            per-channel request level, held until done
//                                or abort
//   Period_i   in   4*CntWidth   per-channel period, channel k at
//                                [k*CntWidth +: CntWidth]
//   Grant_o    out  4            one-hot owner indication, zero when idle
//   Done_o     out  4            one-cycle pulse on the owner's bit at expiry
//   Busy_o     out  1            high whenever a run is in progress
//   CurChan_o  out  2            index of the current or last owner
//
// Run timeline for a period P, where E0 is the arbitration edge:
//   E0        idle -> load  (owner registered, grant visible)
//   E0+1      load -> count (timer <= P)
//   E0+P+2    count -> done (timer reached zero)
//   E0+P+3    done -> idle
// Back-to-back runs are therefore spaced P+4 cycles apart.
//
// Every output is decoded from registered state only. No input can reach an
// output within the same cycle.
// ---------------------------------------------------------------------------
module timer_share_arbiter #(
  parameter int CntWidth = 32
) (
  input  logic                  Reset_n_i,
  input  logic                  Clk_i,
  input  logic                  Enable_i,
  input  logic [3:0]            Req_i,
  input  logic [4*CntWidth-1:0] Period_i,
  output logic [3:0]            Grant_o,
  output logic [3:0]            Done_o,
  output logic                  Busy_o,
  output logic [1:0]            CurChan_o
);

  typedef enum logic [1:0] {
    stIdle  = 2'd0,
    stLoad  = 2'd1,
    stCount = 2'd2,
    stDone  = 2'd3
  } state_t;

  state_t              State_q, State_d;
  logic [CntWidth-1:0] Timer_q, Timer_d;
  logic [1:0]          Winner_q, Winner_d;
  logic [1:0]          LastGrant_q, LastGrant_d;

  // -------------------------------------------------------------------------
  // Round-robin pick.
  // Search order is LastGrant+1, +2, +3, +4 (mod 4). The request vector is
  // doubled and sliced at LastGrant+1. After that, the first set bit of the
  // slice is a plain lowest-index priority encode. Adding its offset back to
  // the start (2-bit wrap) gives the absolute channel.
  // -------------------------------------------------------------------------
  logic [1:0] rr_start;
  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] rr_offset;
  logic [1:0] rr_pick;
  logic       rr_valid;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rr_start  = LastGrant_q + 2'd1;
    req_dbl   = {Req_i, Req_i};
    req_rot   = req_dbl[rr_start +: 4];
    rr_offset = 2'd0;
    // The loop counts down, so the last assignment is the lowest set bit.
    for (int j = 3; j >= 0; j--) begin
      if (req_rot[j]) begin
        rr_offset = 2'(j);
      end
    end
    rr_pick  = rr_start + rr_offset;
    rr_valid = |Req_i;
  end

  // -------------------------------------------------------------------------
  // Period of the current owner. The mux is written as a loop, so the slice
  // bounds stay constant for any CntWidth.
  // -------------------------------------------------------------------------
  logic [CntWidth-1:0] period_sel;

  always_comb begin
    period_sel = '0;
    for (int k = 0; k < 4; k++) begin
      if (Winner_q == 2'(k)) begin
        period_sel = Period_i[k*CntWidth +: CntWidth];
      end
    end
  end

  // The owner gave up (request dropped) or the block was disabled.
  // This is only meaningful while in stLoad or stCount.
  logic abort;
  assign abort = !Enable_i || !Req_i[Winner_q];

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    State_d     = State_q;
    Timer_d     = Timer_q;
    Winner_d    = Winner_q;
    LastGrant_d = LastGrant_q;

    unique case (State_q)
      stIdle: begin
        if (Enable_i && rr_valid) begin
          Winner_d = rr_pick;
          State_d  = stLoad;
        end
      end

      stLoad: begin
        if (abort) begin
          // An aborted run still counts as the owner's turn for rotation.
          LastGrant_d = Winner_q;
          State_d     = stIdle;
        end else begin
          Timer_d = period_sel;
          State_d = stCount;
        end
      end

      stCount: begin
        if (abort) begin
          // The timer keeps its value. It is reloaded before its next use.
          LastGrant_d = Winner_q;
          State_d     = stIdle;
        end else if (Timer_q == '0) begin
          State_d = stDone;
        end else begin
          Timer_d = Timer_q - 1'b1;
        end
      end

      stDone: begin
        // No abort check here. Once expiry is reached, the pulse completes.
        LastGrant_d = Winner_q;
        State_d     = stIdle;
      end

      default: begin
        State_d = stIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers.
  // LastGrant resets to 3, so that channel 0 is first in the search order.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      State_q     <= stIdle;
      Timer_q     <= '0;
      Winner_q    <= 2'd0;
      LastGrant_q <= 2'd3;
    end else begin
      State_q     <= State_d;
      Timer_q     <= Timer_d;
      Winner_q    <= Winner_d;
      LastGrant_q <= LastGrant_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (registers only).
  // -------------------------------------------------------------------------
  logic [3:0] owner_onehot;
  assign owner_onehot = 4'd1 << Winner_q;

  assign Busy_o    = (State_q != stIdle);
  assign Grant_o   = Busy_o ? owner_onehot : 4'd0;
  assign Done_o    = (State_q == stDone) ? owner_onehot : 4'd0;
  assign CurChan_o = Winner_q;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_timer_share_arbiter
//
// Self-checking bench for timer_share_arbiter. A reference model tracks each
// run as an owner plus the edge at which it was granted. Expected outputs
// come from the run's cycle offset against the documented timeline:
//   grant      from E0 until E0+P+3
//   done pulse after E0+P+2
// Abort and round-robin order follow the same rules. Inputs are driven 1 time
// unit after each rising edge, and outputs are compared at that same point.
// ---------------------------------------------------------------------------
module tb_timer_share_arbiter;

  localparam int W = 32;

  logic           Reset_n_i;
  logic           Clk_i;
  logic           Enable_i;
  logic [3:0]     Req_i;
  logic [4*W-1:0] Period_i;
  logic [3:0]     Grant_o;
  logic [3:0]     Done_o;
  logic           Busy_o;
  logic [1:0]     CurChan_o;

  timer_share_arbiter #(.CntWidth(W)) dut (
    .Reset_n_i (Reset_n_i),
    .Clk_i     (Clk_i),
    .Enable_i  (Enable_i),
    .Req_i     (Req_i),
    .Period_i  (Period_i),
    .Grant_o   (Grant_o),
    .Done_o    (Done_o),
    .Busy_o    (Busy_o),
    .CurChan_o (CurChan_o)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  int check_cnt = 0;
  int fail_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy;
  logic [1:0] m_owner;
  logic [1:0] m_last;
  longint     m_start;
  longint     m_period;
  longint     edge_n;

  function automatic void model_reset();
    m_busy   = 1'b0;
    m_owner  = 2'd0;
    m_last   = 2'd3;
    m_start  = 0;
    m_period = 64'h7fff_ffff_ffff;
    edge_n   = 0;
  endfunction

  // Applies the inputs currently driven to the upcoming rising edge.
  function automatic void model_step();
    longint rel;
    if (!m_busy) begin
      if (Enable_i && Req_i != 4'd0) begin
        for (int i = 1; i <= 4; i++) begin
          int idx;
          idx = (int'(m_last) + i) % 4;
          if (Req_i[idx] && !m_busy) begin
            m_busy   = 1'b1;
            m_owner  = 2'(idx);
            m_start  = edge_n;
            m_period = 64'h7fff_ffff_ffff;  // unknown until the load edge
          end
        end
      end
    end else begin
      rel = edge_n - m_start;
      if (rel == m_period + 3) begin
        // Done edge: the run ends whatever Enable_i and Req_i are doing.
        m_busy = 1'b0;
        m_last = m_owner;
      end else if (!Enable_i || !Req_i[m_owner]) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else if (rel == 1) begin
        m_period = longint'(Period_i[int'(m_owner)*W +: W]);
      end
    end
    edge_n++;
  endfunction

  task automatic check_outputs();
    logic [3:0] exp_grant;
    logic [3:0] exp_done;
    longint     rel_now;
    rel_now   = (edge_n - 1) - m_start;
    exp_grant = m_busy ? (4'd1 << m_owner) : 4'd0;
    exp_done  = (m_busy && rel_now == m_period + 2) ? (4'd1 << m_owner) : 4'd0;
    check("grant",   32'(Grant_o),   32'(exp_grant));
    check("done",    32'(Done_o),    32'(exp_done));
    check("busy",    32'(Busy_o),    32'(m_busy));
    check("curchan", 32'(CurChan_o), 32'(m_owner));
  endtask

  // One clock: model sees the driven inputs, DUT clocks, outputs compared.
  task automatic tick();
    model_step();
    @(posedge Clk_i);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    Reset_n_i = 1'b0;
    @(posedge Clk_i);
    #1;
    Reset_n_i = 1'b1;
    model_reset();
  endtask

  function automatic void set_period(input int ch, input logic [31:0] p);
    Period_i[ch*W +: W] = p;
  endfunction

  int         done_at;
  int         done_at2;
  int         seq_tick[$];
  logic [3:0] seq_done[$];
  bit         saw_done;

  initial begin
    Reset_n_i = 1'b0;
    Enable_i  = 1'b0;
    Req_i     = 4'd0;
    Period_i  = '0;
    model_reset();
    #12;
    check("rst_grant",   32'(Grant_o),   32'd0);
    check("rst_done",    32'(Done_o),    32'd0);
    check("rst_busy",    32'(Busy_o),    32'd0);
    check("rst_curchan", 32'(CurChan_o), 32'd0);
    @(posedge Clk_i);
    #1;
    Reset_n_i = 1'b1;
    model_reset();

    // Test 1: single channel, period 5.
    Enable_i = 1'b1;
    set_period(0, 32'd5);
    Req_i   = 4'b0001;
    done_at = -1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (Done_o != 4'd0 && done_at < 0) done_at = i;
      if (i == 1) check("t1_grant", 32'(Grant_o), 32'b0001);
      if (i == 8) check("t1_busy_low", 32'(Busy_o), 32'd0);
    end
    check("t1_done_edge", 32'(done_at), 32'd7);
    Req_i = 4'd0;

    // Test 2: channels 0 and 2 together after reset.
    do_reset();
    set_period(0, 32'd3);
    set_period(2, 32'd2);
    Req_i    = 4'b0101;
    done_at  = -1;
    done_at2 = -1;
    for (int i = 0; i <= 12; i++) begin
      tick();
      if (Done_o == 4'b0001 && done_at < 0)  done_at  = i;
      if (Done_o == 4'b0100 && done_at2 < 0) done_at2 = i;
      if (i == 0) check("t2_first_chan",  32'(CurChan_o), 32'd0);
      if (i == 7) check("t2_second_chan", 32'(CurChan_o), 32'd2);
    end
    check("t2_done0_edge", 32'(done_at),  32'd5);
    check("t2_done2_edge", 32'(done_at2), 32'd11);

    // Test 3: all channels requesting, period 0 everywhere.
    do_reset();
    Period_i = '0;
    Req_i    = 4'b1111;
    seq_tick.delete();
    seq_done.delete();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Done_o != 4'd0) begin
        seq_tick.push_back(i);
        seq_done.push_back(Done_o);
      end
    end
    check("t3_ndone", 32'(seq_tick.size()), 32'd5);
    for (int n = 0; n < 5 && n < seq_tick.size(); n++) begin
      check("t3_done_tick", 32'(seq_tick[n]), 32'(2 + 4*n));
      check("t3_done_chan", 32'(seq_done[n]), 32'(4'd1 << (n % 4)));
    end

    // Test 4: owner drops its request mid-count.
    do_reset();
    set_period(1, 32'd10);
    set_period(2, 32'd3);
    Req_i    = 4'b0110;
    saw_done = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (Done_o != 4'd0) saw_done = 1'b1;
      if (i == 0) check("t4_owner", 32'(CurChan_o), 32'd1);
      if (i == 4) Req_i = 4'b0100;
      if (i == 5) begin
        check("t4_idle", 32'(Busy_o), 32'd0);
        Req_i = 4'b0110;
      end
      if (i == 6) check("t4_next_chan", 32'(CurChan_o), 32'd2);
    end
    check("t4_no_done", 32'(saw_done), 32'd0);
    Req_i = 4'd0;
    for (int i = 0; i < 8; i++) tick();

    // Test 5: asynchronous reset in the middle of a long run.
    do_reset();
    set_period(0, 32'd100);
    Req_i = 4'b0001;
    for (int i = 0; i <= 20; i++) tick();
    #2;
    Reset_n_i = 1'b0;
    #1;
    check("t5_async_grant", 32'(Grant_o), 32'd0);
    check("t5_async_busy",  32'(Busy_o),  32'd0);
    check("t5_async_done",  32'(Done_o),  32'd0);
    @(posedge Clk_i);
    #1;
    Reset_n_i = 1'b1;
    model_reset();
    Req_i = 4'b1111;
    set_period(0, 32'd1);
    tick();
    check("t5_first_after_rst", 32'(Grant_o), 32'b0001);
    for (int i = 0; i < 10; i++) tick();

    // Test 6: disabled, then an abort of a huge period.
    do_reset();
    Enable_i = 1'b0;
    Req_i    = 4'b1111;
    for (int i = 0; i < 20; i++) tick();
    check("t6_dis_busy",  32'(Busy_o),  32'd0);
    check("t6_dis_grant", 32'(Grant_o), 32'd0);
    Enable_i = 1'b1;
    set_period(0, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) tick();
    check("t6_counting", 32'(Grant_o), 32'b0001);
    Enable_i = 1'b0;
    tick();
    check("t6_abort_busy", 32'(Busy_o), 32'd0);
    check("t6_abort_done", 32'(Done_o), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    Enable_i = 1'b1;
    Req_i    = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(7) == 0) Req_i[k] = ~Req_i[k];
        if ($urandom_range(3) == 0) set_period(k, 32'($urandom_range(7)));
      end
      Enable_i = ($urandom_range(15) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
